// File: rtl/joy_sniff6_smd_pkg.sv
// Shared joypad definitions: port addresses, key bit indices and TH phase decode.
// The save-state controller uses the same key indices for its hotkey compares.
package joy_sniff6_smd_pkg;

  localparam logic [23:0] JOY_PORT1_ADDR = 24'hA10002;
  localparam logic [23:0] JOY_PORT2_ADDR = 24'hA10004;
  localparam logic [2:0]  TH_CNT_MAX     = 3'd4;

  typedef enum logic [2:0] {
    KEY_UP    = 3'd0,
    KEY_DOWN  = 3'd1,
    KEY_LEFT  = 3'd2,
    KEY_RIGHT = 3'd3,
    KEY_B     = 3'd4,
    KEY_C     = 3'd5,
    KEY_A     = 3'd6,
    KEY_START = 3'd7
  } key_idx_e;

  typedef enum logic [1:0] {
    KEY_Z    = 2'd0,
    KEY_Y    = 2'd1,
    KEY_X    = 2'd2,
    KEY_MODE = 2'd3
  } ext_idx_e;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_HI   = 3'd1,
    PH_LO   = 3'd2,
    PH_LO3  = 3'd3,
    PH_HI3  = 3'd4
  } phase_e;

  // Which bits a completed pad read carries, given the TH level and low-going TH count.
  function automatic phase_e decode_phase(input logic th, input logic [2:0] cnt);
    phase_e ph;
    ph = PH_NONE;
    if (th) begin
      if (cnt <= 3'd2) begin
        ph = PH_HI;
      end else if (cnt == 3'd3) begin
        ph = PH_HI3;
      end else begin
        ph = PH_NONE;
      end
    end else begin
      if ((cnt == 3'd1) || (cnt == 3'd2)) begin
        ph = PH_LO;
      end else if (cnt == 3'd3) begin
        ph = PH_LO3;
      end else begin
        ph = PH_NONE;
      end
    end
    return ph;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse, on the negedge clock domain.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_sig;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/joy_sniff6_smd.sv
// Snoops 68k accesses to one joypad port and decodes the TH-multiplexed 3/6-button protocol.
// Define JOY6_TIMEOUT_EN to add the idle timeout that restarts the TH phase count.
module joy_sniff6_smd
  import joy_sniff6_smd_pkg::*;
#(
  parameter logic [23:0] PORT_ADDR = JOY_PORT1_ADDR,
  parameter int          TMO_CYC   = 75000,
  parameter int          TMO_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        as,
  input  logic        oe,
  input  logic        we_lo,
  input  logic [23:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic [7:0]  joy_val,
  output logic [3:0]  joy_ext,
  output logic        pad6,
  output logic        key_stb
);

  logic       w_joy_ce;
  logic       w_wr_raw;
  logic       w_rd;
  logic       w_wr_evt;
  logic       w_rd_end;
  logic       w_tmo;
  logic       w_th_nxt;
  logic [2:0] w_cnt_base;
  logic [2:0] w_cnt_nxt;
  logic [7:0] w_keys;
  phase_e     w_phase;

  logic       r_wr_th;
  logic       r_th;
  logic [2:0] r_th_cnt;
  logic       r_rd_prev;
  logic       r_rd_vld;
  logic [7:0] r_rd_latch;
  logic [7:0] r_joy_val;
  logic [3:0] r_joy_ext;
  logic       r_pad6;
  logic       r_key_stb;

  if ((2 ** TMO_W) <= TMO_CYC) begin : g_tmo_w_too_small
    $error("TMO_W too narrow for TMO_CYC");
  end

  assign w_joy_ce = ~as & (cpu_addr == PORT_ADDR);
  assign w_wr_raw = w_joy_ce & ~we_lo;
  assign w_rd     = w_joy_ce & ~oe;
  assign w_keys   = ~r_rd_latch;
  assign w_phase  = decode_phase(r_th, r_th_cnt);
  assign w_rd_end = r_rd_vld & ~w_rd;

  sync_edge u_wr_sync (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (w_wr_raw),
    .o_rise (w_wr_evt)
  );

`ifdef JOY6_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  logic [TMO_W-1:0] r_tmo_ctr;

  assign w_tmo = (r_tmo_ctr == TMO_W'(TMO_CYC - 1));

  // Idle cycles since the last TH write; saturates so the timeout fires once per gap.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_ctr <= {TMO_W{1'b0}};
    end else if (w_wr_evt) begin
      r_tmo_ctr <= {TMO_W{1'b0}};
    end else if (r_tmo_ctr != TMO_W'(TMO_CYC)) begin
      r_tmo_ctr <= r_tmo_ctr + {{(TMO_W - 1){1'b0}}, 1'b1};
    end
  end
`else
  localparam bit TMO_EN = 1'b0;
  assign w_tmo = 1'b0;
`endif

  // Next TH level and phase count: timeout clear first, then any write on top of it.
  always_comb begin
    w_cnt_base = w_tmo ? 3'd0 : r_th_cnt;
    w_th_nxt   = r_th;
    w_cnt_nxt  = w_cnt_base;
    if (w_wr_evt) begin
      w_th_nxt = r_wr_th;
      if (r_th && !r_wr_th) begin
        w_cnt_nxt = (w_cnt_base == TH_CNT_MAX) ? TH_CNT_MAX : (w_cnt_base + 3'd1);
      end else if (!TMO_EN && !r_th && r_wr_th && (r_th_cnt == TH_CNT_MAX)) begin
        w_cnt_nxt = 3'd0;
      end else begin
        w_cnt_nxt = w_cnt_base;
      end
    end else begin
      w_cnt_nxt = w_cnt_base;
    end
  end

  // Write data is captured while the strobe is live, since the synced edge arrives later.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_wr_th  <= 1'b1;
      r_th     <= 1'b1;
      r_th_cnt <= 3'd0;
    end else begin
      if (w_wr_raw) begin
        r_wr_th <= cpu_data[6];
      end
      r_th     <= w_th_nxt;
      r_th_cnt <= w_cnt_nxt;
    end
  end

  // Read window tracking; r_rd_prev resets high so a read spanning reset never decodes.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_rd_prev  <= 1'b1;
      r_rd_vld   <= 1'b0;
      r_rd_latch <= 8'hFF;
    end else begin
      r_rd_prev <= w_rd;
      if (w_rd) begin
        r_rd_latch <= cpu_data;
        if (!r_rd_prev) begin
          r_rd_vld <= 1'b1;
        end
      end else begin
        r_rd_vld <= 1'b0;
      end
    end
  end

  // Key outputs: timeout clear, then the decode of a just-finished read.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_joy_val <= 8'h00;
      r_joy_ext <= 4'h0;
      r_pad6    <= 1'b0;
      r_key_stb <= 1'b0;
    end else begin
      r_key_stb <= 1'b0;
      if (w_tmo && (r_th_cnt < 3'd3)) begin
        r_pad6    <= 1'b0;
        r_joy_ext <= 4'h0;
        r_key_stb <= 1'b1;
      end
      if (w_rd_end) begin
        case (w_phase)
          PH_HI: begin
            r_joy_val[5:0] <= w_keys[5:0];
            r_key_stb      <= 1'b1;
          end
          PH_LO: begin
            r_joy_val[7:6] <= w_keys[5:4];
            r_key_stb      <= 1'b1;
          end
          PH_LO3: begin
            r_pad6         <= (r_rd_latch[3:0] == 4'h0);
            r_joy_val[7:6] <= w_keys[5:4];
            r_key_stb      <= 1'b1;
          end
          PH_HI3: begin
            r_joy_ext <= r_pad6 ? w_keys[3:0] : 4'h0;
            r_key_stb <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign joy_val = r_joy_val;
  assign joy_ext = r_joy_ext;
  assign pad6    = r_pad6;
  assign key_stb = r_key_stb;

endmodule

// File: doc/joy_sniff6_smd.md
Name: joy_sniff6_smd

Overview:
Upstream stage of the SMD save-state controller. Snoops 68k bus accesses to a joypad port and decodes the TH-multiplexed 3-button and 6-button pad protocol. Produces a stable active-high key vector for hotkey matching. Outputs a 3-button-compatible byte in the existing joy_val format plus extended Mode/X/Y/Z keys and a 6-button-present flag.

Parameters:
PORT_ADDR, 24'hA10002, word address of the snooped data port (24'hA10004 for port 2)
TMO_CYC, 75000, clk cycles without a TH write before the phase counter resets (1.5 ms at 50 MHz)
TMO_W, 17, width of the timeout counter; must satisfy 2^TMO_W > TMO_CYC

Ports:
clk  in  1  system clock; all logic on negedge clk, codebase convention
rst  in  1  asynchronous, active-high reset
as  in  1  68k address strobe, active low
oe  in  1  bus read strobe, active low
we_lo  in  1  low-byte write strobe, active low
cpu_addr  in  24  68k byte address bus
cpu_data  in  8  68k data bus low byte, write data or pad read data
joy_val  out  8  {Start,A,C,B,Right,Left,Down,Up}, active high
joy_ext  out  4  {Mode,X,Y,Z}, active high
pad6  out  1  6-button pad detected in the most recent TH sequence
key_stb  out  1  one-cycle pulse after any joy_val/joy_ext/pad6 update

Behaviour:
- Reset: joy_val=0, joy_ext=0, pad6=0, key_stb=0, th=1, th_cnt=0, tmo_ctr=0, rd_latch=0xFF.
- joy_ce = !as & cpu_addr==PORT_ADDR. Write event is the synchronised rising edge of (joy_ce & !we_lo), one cycle, via sync_edge. Read end is the cycle where (joy_ce & !oe) drops from 1 to 0.
- Write event:
  - th <= cpu_data[6].
  - If th transitions 1->0, th_cnt increments, saturating at 4.
  - tmo_ctr <= 0.
- While joy_ce & !oe, rd_latch <= cpu_data every cycle. At read end, decode using the current th and th_cnt, with keys = ~rd_latch:
  - th=1, th_cnt<=2: joy_val[5:0] <= keys[5:0].
  - th=0, th_cnt in 1..2: joy_val[7:6] <= keys[5:4].
  - th=0, th_cnt==3: pad6 <= (rd_latch[3:0]==0). Also joy_val[7:6] <= keys[5:4].
  - th=1, th_cnt==3: joy_ext <= pad6 ? keys[3:0] : 0.
  - th_cnt==4, or th=0 with th_cnt==0: no update.
  - key_stb pulses the cycle after any decode update, even if the values are unchanged.
- Timeout:
  - tmo_ctr increments each cycle without a write event, saturating at TMO_CYC.
  - On reaching TMO_CYC-1: th_cnt <= 0.
  - At the same point, if the just-ended window never reached th_cnt==3: pad6 <= 0, joy_ext <= 0, and key_stb pulses.
- Simultaneous events:
  - Write event and timeout in the same cycle: the timeout clear applies first, then the write. th_cnt becomes 1 on a 1->0 TH write, otherwise 0; tmo_ctr=0.
  - Read end and write event in the same cycle: decode uses the pre-write th and th_cnt.
- Reset asserted mid-sequence returns everything to reset values immediately. A read in flight is discarded.
- Latency: outputs are valid 1 cycle after read end; key_stb is coincident with the new values.

Optional Feature:
JOY6_TIMEOUT_EN
- Defined: timeout counter and the behaviour above are present.
- Undefined: no timeout counter. th_cnt resets to 0 only on a write event where TH goes 0->1 while th_cnt==4, or on rst. pad6 is cleared only by rst or by a th_cnt==3 read showing nonzero rd_latch[3:0]. TMO_CYC and TMO_W are unused.

Decomposition:
- Shared defs include: JOY_PORT1_ADDR, JOY_PORT2_ADDR, and key bit indices KEY_UP..KEY_START and KEY_Z..KEY_MODE. The save-state controller uses the same indices for hotkey compares.
- No new sub-module: reuse the existing sync_edge for the write strobe.
- The read-end detector and timeout counter stay inline.

Test Plan:
- 3-button read: write TH=1, read 0xFE (Up pressed), write TH=0, read 0xEF (A pressed) -> joy_val=0x41, joy_ext=0, pad6=0, two key_stb pulses.
- 6-button sequence: TH 1/0/1/0/1/0/1 with low-phase-3 read 0xF0, then high-phase-3 read 0xF7 -> pad6=1, joy_ext=4'h8 (Mode).
- Timeout: after the 6-button sequence, idle TMO_CYC cycles, then a 3-button sequence -> th_cnt restarts; pad6=0 and joy_ext=0 after the next window, with key_stb on the clear.
- Timeout/write collision: TH 1->0 write landing exactly at tmo_ctr==TMO_CYC-1 -> th_cnt=1, tmo_ctr=0.
- Wrong address or as high: writes to 0xA10004 with PORT_ADDR=0xA10002 -> no th change, no key_stb.
- Reset mid-sequence: assert rst at th_cnt==2 during oe low -> all outputs 0 immediately; the next read end produces no decode.
